axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, giving the number of `AXI_DATA_WIDTH-bit storage words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 'h0, giving the byte address of word 0 (aligned to MEM_WORDS*bytes-per-word).
REQ-003 SHALL have port clk_axi, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ares_axi, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port axi_mosi_i, input, s_axi_mosi_t: AXI4 master-to-slave channels (driven by jtag_axi_wrapper jtag_axi_mosi_o).
REQ-006 SHALL have port axi_miso_o, output, s_axi_miso_t: AXI4 slave-to-master channels (feeding jtag_axi_miso_i).

Function
REQ-007 SHALL run independent write and read FSMs, each with at most one outstanding transaction.
REQ-008 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; the transitions SHALL be W_IDLE->W_DATA on awvalid&awready, W_DATA->W_RESP on wvalid&wready&wlast, and W_RESP->W_IDLE on bvalid&bready.
REQ-009 awready SHALL be 1 only in W_IDLE; wready SHALL be 1 only in W_DATA; bvalid SHALL be 1 only in W_RESP and held until bready.
REQ-010 On the AW handshake the block SHALL latch awid, awaddr, awlen, awsize, awburst; bid SHALL equal the latched awid.
REQ-011 Each W beat SHALL write byte lanes of the addressed word where wstrb=1; lanes with wstrb=0 SHALL be unchanged.
REQ-012 Beat address SHALL be computed as follows: for INCR, add bytes-per-word after each beat; for FIXED, keep the address constant.
REQ-013 Word index SHALL be (addr-BASE_ADDR)>>log2(bytes-per-word); a beat SHALL be out-of-range if addr<BASE_ADDR or index>=MEM_WORDS.
REQ-014 Out-of-range beats SHALL not modify memory; bresp SHALL be SLVERR if any beat errored, else OKAY.
REQ-015 A burst with awburst=WRAP, or awsize != log2(bytes-per-word), SHALL complete all beats without writing and return SLVERR.
REQ-016 If wlast arrives before awlen+1 beats, or is absent on the final beat, the FSM SHALL still move to W_RESP on the (awlen+1)th beat and return SLVERR.
REQ-017 Read FSM SHALL use states R_IDLE and R_DATA; arready SHALL be 1 only in R_IDLE.
REQ-018 On the AR handshake the block SHALL latch the AR fields; rvalid SHALL assert the next cycle with beat 0 data (1-cycle latency).
REQ-019 On each rvalid&rready the next beat SHALL be presented in the following cycle; rlast SHALL be 1 on beat arlen.
REQ-020 After the rlast handshake the read FSM SHALL return to R_IDLE.
REQ-021 rdata, rresp, rlast and rid SHALL be held stable while rvalid&!rready.
REQ-022 Out-of-range, WRAP or bad-size read beats SHALL return rdata=0 and rresp=SLVERR; otherwise rresp=OKAY; rid SHALL equal the latched arid.
REQ-023 For a read and write to the same word in the same cycle, the read SHALL return the pre-write value.
REQ-024 buser and ruser SHALL be 0; unused miso fields SHALL be 0.

Reset
REQ-025 While ares_axi=0 the block SHALL force both FSMs to idle and drive awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=OKAY, rresp=OKAY, rdata=0, bid=0, rid=0.
REQ-026 Reset asserted mid-burst SHALL abort the transaction with no response; memory contents SHALL be unchanged by reset (undefined at power-up).
REQ-027 Deassertion SHALL be synchronous to clk_axi (two-flop reset synchronizer internal).

Verification
REQ-028 Single write: AW addr=BASE+0x10, len=0, W data=0xDEADBEEF, strb=all ones -> bresp=OKAY, bid=awid; a subsequent read of that address returns 0xDEADBEEF with rlast=1.
REQ-029 Partial strobe: write 0xFFFFFFFF, then write 0x00000000 with strb=0b0101 -> readback 0xFF00FF00.
REQ-030 INCR burst: len=3 write at BASE+0x0 with 1,2,3,4, then len=3 read -> rdata 1,2,3,4 with rlast only on beat 3; test with rready toggling every cycle to check that data is held.
REQ-031 Out-of-range: write at BASE+MEM_WORDS*4 -> bresp=SLVERR and memory unchanged; read there -> rdata=0, rresp=SLVERR.
REQ-032 Errors: WRAP burst len=1 -> SLVERR after 2 beats; wlast early on beat 0 of len=1 -> SLVERR after 2 beats.
REQ-033 Reset mid-read burst (len=7, after beat 2) -> rvalid=0 immediately and arready=1; the next read completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// AXI4 slave backed by an on-chip word-addressed SRAM. Independent write and
// read engines, each accepting one burst at a time.
//
// Ports
//   clk_axi    in   single clock, rising edge
//   ares_axi   in   asynchronous active-low reset (deassertion resynchronised)
//   axi_mosi_i in   AXI4 master-to-slave channels (AW, W, B-ready, AR, R-ready)
//   axi_miso_o out  AXI4 slave-to-master channels (ready/valid, B and R payload)
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where valid and ready are both 1. Every ready/valid driven here depends only
// on FSM state, never combinationally on the master's valid or ready.
// -----------------------------------------------------------------------------
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package axi_sram_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = `AXI_DATA_WIDTH;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  buser;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  ruser;
    logic                  rvalid;
  } s_axi_miso_t;
endpackage

module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int                    MEM_WORDS = 256,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic        clk_axi,
  input  logic        ares_axi,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int         BPW       = AXI_STRB_W;
  localparam int         LSB       = $clog2(BPW);
  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [2:0] FULL_SIZE = 3'(LSB);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic addr_oor(input logic [AXI_ADDR_W-1:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> (LSB + IDX_W)) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  // WRAP and the reserved burst encoding are both refused, as is any
  // narrow/wide transfer size.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (burst == 2'b11) || (size != FULL_SIZE);
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] a,
                                                     input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + AXI_ADDR_W'(BPW) : a;
  endfunction

  // Reset asserts asynchronously and releases two clocks later.
  logic r_rst_meta, r_rst_sync;
  always_ff @(posedge clk_axi or negedge ares_axi) begin
    if (!ares_axi) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  logic [AXI_DATA_W-1:0] r_mem [MEM_WORDS];

  // ---------------------------------------------------------------- write
  w_state_t              r_w_state, w_w_state_nxt;
  logic [AXI_ID_W-1:0]   r_aw_id;
  logic [AXI_ADDR_W-1:0] r_aw_addr;   // address of the next W beat
  logic [7:0]            r_aw_len, r_w_cnt;
  logic [2:0]            r_aw_size;
  logic [1:0]            r_aw_burst;
  logic                  r_w_err;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_w_final, w_w_bad, w_w_oor, w_mem_we;

  assign w_aw_hs   = axi_mosi_i.awvalid && (r_w_state == W_IDLE);
  assign w_w_hs    = axi_mosi_i.wvalid  && (r_w_state == W_DATA);
  assign w_b_hs    = axi_mosi_i.bready  && (r_w_state == W_RESP);
  assign w_w_final = (r_w_cnt == r_aw_len);
  assign w_w_bad   = burst_bad(r_aw_burst, r_aw_size);
  assign w_w_oor   = addr_oor(r_aw_addr);
  assign w_mem_we  = w_w_hs && !w_w_bad && !w_w_oor;

  always_ff @(posedge clk_axi or negedge r_rst_sync) begin
    if (!r_rst_sync) r_w_state <= W_IDLE;
    else             r_w_state <= w_w_state_nxt;
  end

  // The burst ends on the beat count, not on wlast; a misplaced wlast only
  // turns the response into SLVERR.
  always_comb begin
    w_w_state_nxt = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_aw_hs)              w_w_state_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_w_final)  w_w_state_nxt = W_RESP;
      W_RESP:  if (w_b_hs)               w_w_state_nxt = W_IDLE;
      default:                           w_w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_w_cnt    <= '0;
      r_w_err    <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_id    <= axi_mosi_i.awid;
      r_aw_addr  <= axi_mosi_i.awaddr;
      r_aw_len   <= axi_mosi_i.awlen;
      r_aw_size  <= axi_mosi_i.awsize;
      r_aw_burst <= axi_mosi_i.awburst;
      r_w_cnt    <= '0;
      r_w_err    <= 1'b0;
    end else if (w_w_hs) begin
      r_w_cnt   <= r_w_cnt + 8'd1;
      r_aw_addr <= next_addr(r_aw_addr, r_aw_burst);
      if (w_w_bad || w_w_oor || (axi_mosi_i.wlast != w_w_final)) r_w_err <= 1'b1;
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk_axi) begin
    if (w_mem_we) begin
      for (int b = 0; b < BPW; b++) begin
        if (axi_mosi_i.wstrb[b]) r_mem[addr_idx(r_aw_addr)][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t              r_r_state, w_r_state_nxt;
  logic [AXI_ID_W-1:0]   r_ar_id;
  logic [AXI_ADDR_W-1:0] r_ar_addr;   // address of the beat on the R channel
  logic [7:0]            r_ar_len, r_r_cnt;
  logic [2:0]            r_ar_size;
  logic [1:0]            r_ar_burst;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic                  w_ar_hs, w_r_hs, w_r_ld, w_ld_err;
  logic [AXI_ADDR_W-1:0] w_ld_addr;
  logic [7:0]            w_ld_cnt, w_ld_len;

  assign w_ar_hs = axi_mosi_i.arvalid && (r_r_state == R_IDLE);
  assign w_r_hs  = axi_mosi_i.rready  && (r_r_state == R_DATA);
  // A beat is fetched on AR acceptance and after every non-final R transfer.
  // The fetch samples storage before this edge's write lands, so a collision
  // returns the old word.
  assign w_r_ld    = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_ld_addr = w_ar_hs ? axi_mosi_i.araddr : next_addr(r_ar_addr, r_ar_burst);
  assign w_ld_cnt  = w_ar_hs ? 8'd0 : r_r_cnt + 8'd1;
  assign w_ld_len  = w_ar_hs ? axi_mosi_i.arlen : r_ar_len;
  assign w_ld_err  = addr_oor(w_ld_addr) ||
                     (w_ar_hs ? burst_bad(axi_mosi_i.arburst, axi_mosi_i.arsize)
                              : burst_bad(r_ar_burst, r_ar_size));

  always_ff @(posedge clk_axi or negedge r_rst_sync) begin
    if (!r_rst_sync) r_r_state <= R_IDLE;
    else             r_r_state <= w_r_state_nxt;
  end

  always_comb begin
    w_r_state_nxt = r_r_state;
    case (r_r_state)
      R_IDLE:  if (w_ar_hs)            w_r_state_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast)  w_r_state_nxt = R_IDLE;
      default:                         w_r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_ar_id    <= '0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_r_cnt    <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_ar_id    <= axi_mosi_i.arid;
        r_ar_len   <= axi_mosi_i.arlen;
        r_ar_size  <= axi_mosi_i.arsize;
        r_ar_burst <= axi_mosi_i.arburst;
      end
      if (w_r_ld) begin
        r_ar_addr <= w_ld_addr;
        r_r_cnt   <= w_ld_cnt;
        r_rlast   <= (w_ld_cnt == w_ld_len);
        r_rdata   <= w_ld_err ? '0 : r_mem[addr_idx(w_ld_addr)];
        r_rresp   <= w_ld_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // --------------------------------------------------------------- outputs
  // Payload fields are forced to zero whenever their valid is low.
  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = (r_w_state == W_IDLE);
    axi_miso_o.wready  = (r_w_state == W_DATA);
    axi_miso_o.bvalid  = (r_w_state == W_RESP);
    axi_miso_o.arready = (r_r_state == R_IDLE);
    axi_miso_o.rvalid  = (r_r_state == R_DATA);
    if (r_w_state == W_RESP) begin
      axi_miso_o.bid   = r_aw_id;
      axi_miso_o.bresp = r_w_err ? RESP_SLVERR : RESP_OKAY;
    end
    if (r_r_state == R_DATA) begin
      axi_miso_o.rid   = r_ar_id;
      axi_miso_o.rdata = r_rdata;
      axi_miso_o.rresp = r_rresp;
      axi_miso_o.rlast = r_rlast;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed and randomized AXI4 traffic against axi_sram_slave, checked against
// a word-array model of the memory and the slave's response rules.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  localparam int          MW   = 256;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] TOP  = BASE + MW * 4;

  // ---------------------------------------------------------- clock / reset
  logic clk_axi = 1'b0;
  logic ares_axi = 1'b0;
  always #5 clk_axi = ~clk_axi;

  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  axi_sram_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clk_axi   (clk_axi),
    .ares_axi  (ares_axi),
    .axi_mosi_i(mosi),
    .axi_miso_o(miso)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_rq[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] mdl_mem[MW];
  logic [1:0]  last_bresp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ----------------------------------------------------------------- model
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int k);
    return (burst == BURST_INCR) ? a + 32'(4 * k) : a;
  endfunction

  function automatic bit beat_err(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (burst == 2'b11) || (size != 3'd2) || (a < BASE) || (a >= TOP);
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input int wlast_beat, output logic [1:0] resp);
    bit err = (wlast_beat != len);
    for (int k = 0; k <= len; k++) begin
      logic [31:0] a = beat_addr(addr, burst, k);
      if (beat_err(a, burst, size)) err = 1;
      else
        for (int b = 0; b < 4; b++)
          if (wq_strb[k][b]) mdl_mem[(a - BASE) / 4][8*b +: 8] = wq_data[k][8*b +: 8];
    end
    resp = err ? RESP_SLVERR : RESP_OKAY;
  endtask

  task automatic model_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size);
    for (int k = 0; k <= len; k++) begin
      logic [31:0] a = beat_addr(addr, burst, k);
      if (beat_err(a, burst, size)) begin
        exp_q.push_back(32'h0);
        exp_rq.push_back(RESP_SLVERR);
      end else begin
        exp_q.push_back(mdl_mem[(a - BASE) / 4]);
        exp_rq.push_back(RESP_OKAY);
      end
    end
  endtask

  // --------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk_axi);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    mosi.awid = id; mosi.awaddr = addr; mosi.awlen = 8'(len);
    mosi.awburst = burst; mosi.awsize = size; mosi.awvalid = 1'b1;
    while (!miso.awready && n < 50) begin step(); n++; end
    chk("awready", miso.awready, 1'b1);
    step();
    mosi.awvalid = 1'b0;
  endtask

  task automatic send_w(input int wlast_beat);
    for (int i = 0; i < wq_data.size(); i++) begin
      int n = 0;
      mosi.wdata = wq_data[i]; mosi.wstrb = wq_strb[i];
      mosi.wlast = (i == wlast_beat); mosi.wvalid = 1'b1;
      while (!miso.wready && n < 50) begin step(); n++; end
      chk("wready", miso.wready, 1'b1);
      step();
    end
    mosi.wvalid = 1'b0;
    mosi.wlast  = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] exp_resp);
    int n = 0;
    mosi.bready = 1'b1;
    while (!miso.bvalid && n < 50) begin step(); n++; end
    chk("bvalid", miso.bvalid, 1'b1);
    chk("bresp", miso.bresp, exp_resp);
    chk("bid", miso.bid, id);
    last_bresp = miso.bresp;
    step();
    mosi.bready = 1'b0;
    chk("bvalid_clr", miso.bvalid, 1'b0);
  endtask

  // Caller fills wq_data / wq_strb with len+1 beats first.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int wlast_beat);
    logic [1:0] resp;
    model_write(addr, len, burst, size, wlast_beat, resp);
    send_aw(id, addr, len, burst, size);
    send_w(wlast_beat);
    get_b(id, resp);
    wq_data.delete();
    wq_strb.delete();
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    mosi.arid = id; mosi.araddr = addr; mosi.arlen = 8'(len);
    mosi.arburst = burst; mosi.arsize = size; mosi.arvalid = 1'b1;
    while (!miso.arready && n < 50) begin step(); n++; end
    chk("arready", miso.arready, 1'b1);
    step();
    mosi.arvalid = 1'b0;
  endtask

  // mode 0: rready always 1; 1: rready toggles starting low; 2: random.
  // Every cycle with rvalid high is checked against the head of exp_q, so a
  // stalled beat must stay unchanged until it is taken.
  task automatic collect_r(input logic [3:0] id, input int len, input int mode, input int abort_after);
    int   beat = 0;
    int   cyc  = 0;
    logic rr;
    chk("r_latency", miso.rvalid, 1'b1);
    while (beat <= len && cyc < 300) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 1);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      mosi.rready = rr;
      if (miso.rvalid) begin
        chk("rdata", miso.rdata, exp_q[0]);
        chk("rresp", miso.rresp, exp_rq[0]);
        chk("rid", miso.rid, id);
        chk("rlast", miso.rlast, (beat == len));
        if (rr) begin
          void'(exp_q.pop_front());
          void'(exp_rq.pop_front());
          beat++;
        end
      end
      step();
      cyc++;
      if (abort_after >= 0 && beat == abort_after) break;
    end
    mosi.rready = 1'b0;
    if (abort_after < 0) begin
      chk("r_beats", beat, len + 1);
      chk("r_idle", miso.arready, 1'b1);
      chk("rvalid_clr", miso.rvalid, 1'b0);
    end
  endtask

  task automatic read_exp(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
    model_read(addr, len, burst, size);
    send_ar(id, addr, len, burst, size);
    collect_r(id, len, mode, -1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_awready"}, miso.awready, 1'b1);
    chk({tag, "_arready"}, miso.arready, 1'b1);
    chk({tag, "_wready"},  miso.wready,  1'b0);
    chk({tag, "_bvalid"},  miso.bvalid,  1'b0);
    chk({tag, "_rvalid"},  miso.rvalid,  1'b0);
    chk({tag, "_rlast"},   miso.rlast,   1'b0);
    chk({tag, "_bresp"},   miso.bresp,   RESP_OKAY);
    chk({tag, "_rresp"},   miso.rresp,   RESP_OKAY);
    chk({tag, "_rdata"},   miso.rdata,   32'h0);
    chk({tag, "_bid"},     miso.bid,     4'h0);
    chk({tag, "_rid"},     miso.rid,     4'h0);
    chk({tag, "_users"},   {miso.buser, miso.ruser}, 2'b00);
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    logic [1:0] resp;
    mosi = '0;

    // Reset state
    repeat (3) step();
    check_idle_outputs("rst");
    ares_axi = 1'b1;
    repeat (4) step();

    // Single write and readback
    wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
    do_write(4'h5, BASE + 32'h10, 0, BURST_INCR, 3'd2, 0);
    chk("single_bresp", last_bresp, RESP_OKAY);
    exp_q.push_back(32'hDEADBEEF); exp_rq.push_back(RESP_OKAY);
    send_ar(4'h3, BASE + 32'h10, 0, BURST_INCR, 3'd2);
    collect_r(4'h3, 0, 0, -1);

    // Partial strobe
    wq_data = '{32'hFFFFFFFF}; wq_strb = '{4'hF};
    do_write(4'h1, BASE + 32'h14, 0, BURST_INCR, 3'd2, 0);
    wq_data = '{32'h00000000}; wq_strb = '{4'b0101};
    do_write(4'h2, BASE + 32'h14, 0, BURST_INCR, 3'd2, 0);
    exp_q.push_back(32'hFF00FF00); exp_rq.push_back(RESP_OKAY);
    send_ar(4'h4, BASE + 32'h14, 0, BURST_INCR, 3'd2);
    collect_r(4'h4, 0, 0, -1);

    // INCR burst, read with rready toggling
    wq_data = '{32'd1, 32'd2, 32'd3, 32'd4}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'h6, BASE, 3, BURST_INCR, 3'd2, 3);
    for (int i = 1; i <= 4; i++) begin exp_q.push_back(32'(i)); exp_rq.push_back(RESP_OKAY); end
    send_ar(4'h7, BASE, 3, BURST_INCR, 3'd2);
    collect_r(4'h7, 3, 1, -1);

    // Out-of-range write and read, below-base read, bad-size read
    wq_data = '{32'hA5A5A5A5}; wq_strb = '{4'hF};
    do_write(4'h8, TOP, 0, BURST_INCR, 3'd2, 0);
    chk("oor_bresp", last_bresp, RESP_SLVERR);
    exp_q.push_back(32'd1); exp_rq.push_back(RESP_OKAY);
    send_ar(4'h9, BASE, 0, BURST_INCR, 3'd2);
    collect_r(4'h9, 0, 0, -1);
    exp_q.push_back(32'h0); exp_rq.push_back(RESP_SLVERR);
    send_ar(4'hA, TOP, 0, BURST_INCR, 3'd2);
    collect_r(4'hA, 0, 0, -1);
    exp_q.push_back(32'h0); exp_rq.push_back(RESP_SLVERR);
    send_ar(4'hB, BASE - 32'h4, 0, BURST_INCR, 3'd2);
    collect_r(4'hB, 0, 0, -1);
    exp_q.push_back(32'h0); exp_rq.push_back(RESP_SLVERR);
    send_ar(4'hC, BASE + 32'h10, 0, BURST_INCR, 3'd1);
    collect_r(4'hC, 0, 0, -1);

    // WRAP burst and early wlast, both two beats
    wq_data = '{32'h11, 32'h22}; wq_strb = '{4'hF, 4'hF};
    do_write(4'hD, BASE + 32'h40, 1, BURST_WRAP, 3'd2, 1);
    chk("wrap_bresp", last_bresp, RESP_SLVERR);
    wq_data = '{32'h33, 32'h44}; wq_strb = '{4'hF, 4'hF};
    do_write(4'hE, BASE + 32'h48, 1, BURST_INCR, 3'd2, 0);
    chk("early_wlast_bresp", last_bresp, RESP_SLVERR);

    // Fill the whole memory with random words
    for (int blk = 0; blk < MW / 16; blk++) begin
      for (int k = 0; k < 16; k++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
      do_write(4'(blk), BASE + 32'(blk * 64), 15, BURST_INCR, 3'd2, 15);
    end

    // Read and write of the same word on the same edge: read sees old data
    model_read(BASE + 32'h20, 0, BURST_INCR, 3'd2);
    wq_data = '{32'hCAFEF00D}; wq_strb = '{4'hF};
    model_write(BASE + 32'h20, 0, BURST_INCR, 3'd2, 0, resp);
    send_aw(4'h2, BASE + 32'h20, 0, BURST_INCR, 3'd2);
    fork
      send_w(0);
      begin
        send_ar(4'h3, BASE + 32'h20, 0, BURST_INCR, 3'd2);
        collect_r(4'h3, 0, 0, -1);
      end
    join
    get_b(4'h2, resp);
    wq_data.delete(); wq_strb.delete();
    read_exp(4'h4, BASE + 32'h20, 0, BURST_INCR, 3'd2, 0);

    // Reset in the middle of an 8-beat read, after three beats
    model_read(BASE + 32'h80, 7, BURST_INCR, 3'd2);
    send_ar(4'h5, BASE + 32'h80, 7, BURST_INCR, 3'd2);
    collect_r(4'h5, 7, 0, 3);
    exp_q.delete(); exp_rq.delete();
    ares_axi = 1'b0;
    #1;
    chk("midrst_rvalid", miso.rvalid, 1'b0);
    chk("midrst_arready", miso.arready, 1'b1);
    @(posedge clk_axi); #1;
    check_idle_outputs("midrst");
    step();
    ares_axi = 1'b1;
    repeat (4) step();
    read_exp(4'h6, BASE + 32'h80, 7, BURST_INCR, 3'd2, 2);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [3:0]  id    = 4'($urandom_range(0, 15));
      int          len   = $urandom_range(0, 7);
      int          kind  = $urandom_range(0, 9);
      logic [1:0]  burst = (kind < 7) ? BURST_INCR : (kind < 9) ? BURST_FIXED : BURST_WRAP;
      logic [2:0]  size  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      logic [31:0] addr  = BASE + 32'(4 * $urandom_range(0, MW + 3));
      if ($urandom_range(0, 15) == 0) addr = BASE - 32'(4 * $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        int wl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : len;
        for (int k = 0; k <= len; k++) begin
          wq_data.push_back($urandom);
          wq_strb.push_back(4'($urandom_range(0, 15)));
        end
        do_write(id, addr, len, burst, size, wl);
      end else begin
        read_exp(id, addr, len, burst, size, $urandom_range(0, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
